adder_tree_pipe: RTL and testbench
==================================

// Module: adder_tree_pipe
// PURPOSE
//  Pipelined, parametrised N-input signed adder tree with valid/ready flow control.
//  Optionally accumulates tree sums across a burst of beats, which makes long LSTM
//  dot products possible from narrow input groups. Also optionally saturates the output.
//  Sits between the multiplier array and the activation unit in the LSTM gate datapath.
// PARAMETERS
//  NUM    8   number of WIDTH-bit operands per beat (>=1; non-power-of-2 zero-padded)
//  WIDTH  32  operand and result width, two's complement
//  GUARD  8   extra accumulator bits beyond WIDTH+LVL (LVL = clog2(NUM))
//  SAT    1   1: saturate result to signed WIDTH; 0: wrap (truncate)
// PORTS
//  clk      in   1          clock, all logic rising-edge
//  rst      in   1          synchronous reset, active-low
//  i        in   NUM*WIDTH  operands; operand k = i[k*WIDTH +: WIDTH]
//  i_valid  in   1          beat on i is valid
//  i_acc    in   1          beat belongs to an accumulation burst
//  i_last   in   1          final beat of a burst (ignored when i_acc=0)
//  i_ready  out  1          block accepts a beat this cycle
//  o        out  WIDTH      result
//  o_valid  out  1          o is valid
//  o_ovf    out  1          saturation/wrap occurred producing this o
//  o_ready  in   1          downstream accepts o
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): all pipeline valids=0, accumulator=0, burst-active=0,
//    o=0, o_valid=0, o_ovf=0. Beats in flight are discarded. A partial burst is discarded.
//  - Global stall: adv = o_ready | ~o_valid; i_ready = adv. All stages load only when adv=1.
//    A beat is accepted when i_valid & i_ready. While stalled, o/o_valid/o_ovf hold stable.
//  - Tree: LVL registered stages. Stage s sums adjacent pairs of stage s-1.
//    Each level widens by 1 bit: stage s is WIDTH+s bits, sign-extended, so the tree never overflows.
//    i_acc/i_last/valid travel with the data as sideband.
//  - Output stage (1 register), fed by tree sum T (WIDTH+LVL bits):
//      i_acc=0           : R = T; emit.
//      i_acc=1, ~last    : acc <= (burst-active ? acc : 0) + T; burst-active<=1; no emit.
//      i_acc=1, last     : R = (burst-active ? acc : 0) + T; emit; acc<=0; burst-active<=0.
//    acc is WIDTH+LVL+GUARD bits. Accumulator overflow beyond that width wraps silently (not flagged).
//  - Emit: o = SAT ? clamp(R, -2^(W-1), 2^(W-1)-1) : R[WIDTH-1:0].
//    o_ovf=1 iff R is outside the signed WIDTH range. o_valid=1.
//  - A non-acc beat arriving mid-burst is emitted alone. It leaves acc and burst-active untouched.
//  - Latency: LVL+1 cycles from acceptance to o_valid with no stalls (NUM=8 -> 4; NUM=1 -> 1).
//    Throughput: 1 beat/cycle.
//  - Bubbles (i_valid=0) propagate as invalid beats and never alter acc.
// STRUCTURE
//  - Package adder_pkg: clog2 function, LVL/ACCW width constants, saturate/clamp function.
//  - Sub-module adder_stage (NUM_IN, W_IN): one registered tree level.
//    It pads odd counts with 0, has an enable port, and passes the sideband bits through.
//    The top level generates LVL instances plus the accumulate/saturate output stage.
// TESTING
//  1. NUM=8, W=32, one beat 1..8, o_ready=1 -> o=36, o_valid pulse 4 cycles after accept, o_ovf=0.
//  2. SAT=1, eight operands 0x7FFFFFFF -> o=0x7FFFFFFF, o_ovf=1.
//     SAT=0, same beat -> o=0xFFFFFFF8, o_ovf=1.
//  3. Burst of 3 acc beats, each all-ones (-1 x8), last on beat 3 -> single o=-24 (0xFFFFFFE8).
//     No output on beats 1-2.
//  4. Back-to-back beats (sums 10,20,30) with o_ready low for 3 cycles at the second result.
//     -> i_ready=0 during the stall, outputs 10,20,30 in order, no loss or duplication.
//  5. rst=0 mid-burst after 2 acc beats, then a new burst of 1 last beat sum 5
//     -> o=5 (old partial sum discarded); o_valid=0 during and right after reset.
//  6. NUM=5 (padding), operands -3,4,-5,6,7 -> o=9 after 4 cycles.
//     Also NUM=1 -> o=i after 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared widths, beat classification and result saturation for the adder tree.
package adder_pkg;

  // Widest signed value the saturation helper handles; must cover the accumulator.
  localparam int unsigned MAXW = 128;

  // How the output stage treats a tree sum.
  typedef enum logic [1:0] {
    BEAT_PLAIN = 2'd0,  // standalone beat, emitted on its own
    BEAT_MID   = 2'd1,  // accumulation beat that is not the last of its burst
    BEAT_LAST  = 2'd2   // closing beat of a burst, emits the running total
  } beat_e;

  // Saturation result: candidate output value plus out-of-range flag.
  typedef struct packed {
    logic             ovf;
    logic [MAXW-1:0]  val;
  } sat_t;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    for (v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Number of registered tree levels for a given operand count.
  function automatic int unsigned lvl_of(input int unsigned num);
    return clog2(num);
  endfunction

  // Accumulator width: tree result width plus guard bits.
  function automatic int unsigned accw_of(input int unsigned width, input int unsigned num,
                                          input int unsigned guard);
    return width + clog2(num) + guard;
  endfunction

  // Operand count present at tree level s (level 0 is the raw input).
  function automatic int unsigned cnt_at(input int unsigned num, input int unsigned s);
    return (num + (32'd1 << s) - 32'd1) >> s;
  endfunction

  // Classify a tree sum from its sideband bits.
  function automatic beat_e beat_kind(input logic acc, input logic last);
    if (!acc)      return BEAT_PLAIN;
    else if (last) return BEAT_LAST;
    else           return BEAT_MID;
  endfunction

  // Range-check r against signed w bits; clamp when sat is set, pass through otherwise.
  function automatic sat_t saturate(input logic signed [MAXW-1:0] r, input int unsigned w,
                                    input logic sat);
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    sat_t                   res;
    one    = '0;
    one[0] = 1'b1;
    hi     = (one <<< (w - 32'd1)) - one;
    lo     = -hi - one;
    res.ovf = (r > hi) || (r < lo);
    res.val = r;
    if (sat && (r > hi))      res.val = hi;
    else if (sat && (r < lo)) res.val = lo;
    return res;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered level of the adder tree: sums adjacent operand pairs, widening by one bit.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned W_IN   = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [NUM_IN*W_IN-1:0]                opnd,
  input  logic                                  vld,
  input  logic                                  acc,
  input  logic                                  last,
  output logic [((NUM_IN+1)/2)*(W_IN+1)-1:0]    sum,
  output logic                                  sum_vld,
  output logic                                  sum_acc,
  output logic                                  sum_last
);

  localparam int unsigned NUM_OUT = (NUM_IN + 1) / 2;
  localparam int unsigned W_OUT   = W_IN + 1;

  logic [NUM_OUT*W_OUT-1:0] sum_nxt;

  // Pairwise sign-extended sums; an odd trailing operand is paired with zero.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_pair
    logic signed [W_OUT-1:0] a;
    logic signed [W_OUT-1:0] b;
    assign a = {opnd[(2*k+1)*W_IN-1], opnd[2*k*W_IN +: W_IN]};
    if (2*k + 1 < NUM_IN) begin : g_two
      assign b = {opnd[(2*k+2)*W_IN-1], opnd[(2*k+1)*W_IN +: W_IN]};
    end else begin : g_pad
      assign b = '0;
    end
    assign sum_nxt[k*W_OUT +: W_OUT] = a + b;
  end

  // Level register with sideband; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum      <= '0;
      sum_vld  <= 1'b0;
      sum_acc  <= 1'b0;
      sum_last <= 1'b0;
    end else if (en) begin
      sum      <= sum_nxt;
      sum_vld  <= vld;
      sum_acc  <= acc;
      sum_last <= last;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree with optional burst accumulation and output saturation.
module adder_tree_pipe
  import adder_pkg::*;
#(
  parameter int unsigned NUM   = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GUARD = 8,
  parameter bit          SAT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM*WIDTH-1:0]  i,
  input  logic                  i_valid,
  input  logic                  i_acc,
  input  logic                  i_last,
  output logic                  i_ready,
  output logic [WIDTH-1:0]      o,
  output logic                  o_valid,
  output logic                  o_ovf,
  input  logic                  o_ready
);

  localparam int unsigned LVL  = lvl_of(NUM);
  localparam int unsigned TW   = WIDTH + LVL;
  localparam int unsigned ACCW = accw_of(WIDTH, NUM, GUARD);

  logic                  adv;
  logic signed [TW-1:0]  tsum;
  logic                  t_vld;
  logic                  t_acc;
  logic                  t_last;

  // Whole pipeline advances together whenever the output register can be refilled.
  assign adv     = o_ready | ~o_valid;
  assign i_ready = adv;

  if (LVL == 0) begin : g_flat
    // Single operand: no tree levels, the output stage sees the input directly.
    assign tsum   = i;
    assign t_vld  = i_valid;
    assign t_acc  = i_acc;
    assign t_last = i_last;
  end else begin : g_tree
    for (genvar s = 1; s <= LVL; s++) begin : g_lvl
      localparam int unsigned NI = cnt_at(NUM, s - 1);
      localparam int unsigned NO = cnt_at(NUM, s);
      localparam int unsigned WI = WIDTH + s - 1;

      logic [NI*WI-1:0]      opnd;
      logic                  vld;
      logic                  acc;
      logic                  last;
      logic [NO*(WI+1)-1:0]  sum;
      logic                  sum_vld;
      logic                  sum_acc;
      logic                  sum_last;

      if (s == 1) begin : g_src
        assign opnd = i;
        assign vld  = i_valid;
        assign acc  = i_acc;
        assign last = i_last;
      end else begin : g_chain
        assign opnd = g_lvl[s-1].sum;
        assign vld  = g_lvl[s-1].sum_vld;
        assign acc  = g_lvl[s-1].sum_acc;
        assign last = g_lvl[s-1].sum_last;
      end

      adder_stage #(
        .NUM_IN (NI),
        .W_IN   (WI)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .opnd     (opnd),
        .vld      (vld),
        .acc      (acc),
        .last     (last),
        .sum      (sum),
        .sum_vld  (sum_vld),
        .sum_acc  (sum_acc),
        .sum_last (sum_last)
      );
    end

    assign tsum   = g_lvl[LVL].sum;
    assign t_vld  = g_lvl[LVL].sum_vld;
    assign t_acc  = g_lvl[LVL].sum_acc;
    assign t_last = g_lvl[LVL].sum_last;
  end

  logic signed [ACCW-1:0]  acc;
  logic                    burst;
  logic signed [ACCW-1:0]  t_ext;
  logic signed [ACCW-1:0]  rsum;
  logic signed [ACCW-1:0]  rsel;
  logic signed [MAXW-1:0]  rwide;
  logic                    emit;
  beat_e                   kind;
  sat_t                    sres;

  // Result selection: running total for accumulation beats, raw tree sum otherwise.
  always_comb begin
    t_ext = ACCW'(tsum);
    rsum  = (burst ? acc : '0) + t_ext;
    kind  = beat_kind(t_acc, t_last);
    rsel  = (kind == BEAT_PLAIN) ? t_ext : rsum;
    emit  = t_vld && (kind != BEAT_MID);
    rwide = MAXW'(rsel);
    sres  = saturate(rwide, WIDTH, SAT);
  end

  // Output register and burst accumulator; both frozen during a stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o       <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      acc     <= '0;
      burst   <= 1'b0;
    end else if (adv) begin
      o_valid <= emit;
      if (emit) begin
        o     <= WIDTH'(sres.val);
        o_ovf <= sres.ovf;
      end
      if (t_vld && (kind == BEAT_MID)) begin
        acc   <= rsum;
        burst <= 1'b1;
      end else if (t_vld && (kind == BEAT_LAST)) begin
        acc   <= '0;
        burst <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed checks of adder_tree_pipe across saturating, wrapping, padded and single-operand builds.
module tb_adder_tree_pipe;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [8*W-1:0] i8;
  logic          v8, acc8, last8, ordy;
  logic          rdy_s, ov_s, ovf_s;
  logic [W-1:0]  o_s;
  logic          rdy_w, ov_w, ovf_w;
  logic [W-1:0]  o_w;
  logic [5*W-1:0] i5;
  logic          v5, rdy5, ov5, ovf5;
  logic [W-1:0]  o5;
  logic [W-1:0]  i1;
  logic          v1, rdy1, ov1, ovf1;
  logic [W-1:0]  o1;

  int unsigned n_cmp, n_err;
  int unsigned nout, at, nxt;
  logic [W-1:0] got [0:3];
  logic          gotovf;
  logic [W-1:0]  sums [0:2];

  adder_tree_pipe #(.NUM(8), .WIDTH(W), .GUARD(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .i(i8), .i_valid(v8), .i_acc(acc8), .i_last(last8),
    .i_ready(rdy_s), .o(o_s), .o_valid(ov_s), .o_ovf(ovf_s), .o_ready(ordy));

  adder_tree_pipe #(.NUM(8), .WIDTH(W), .GUARD(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .i(i8), .i_valid(v8), .i_acc(acc8), .i_last(last8),
    .i_ready(rdy_w), .o(o_w), .o_valid(ov_w), .o_ovf(ovf_w), .o_ready(ordy));

  adder_tree_pipe #(.NUM(5), .WIDTH(W), .GUARD(8), .SAT(1'b1)) u_n5 (
    .clk(clk), .rst(rst), .i(i5), .i_valid(v5), .i_acc(1'b0), .i_last(1'b0),
    .i_ready(rdy5), .o(o5), .o_valid(ov5), .o_ovf(ovf5), .o_ready(1'b1));

  adder_tree_pipe #(.NUM(1), .WIDTH(W), .GUARD(8), .SAT(1'b1)) u_n1 (
    .clk(clk), .rst(rst), .i(i1), .i_valid(v1), .i_acc(1'b0), .i_last(1'b0),
    .i_ready(rdy1), .o(o1), .o_valid(ov1), .o_ovf(ovf1), .o_ready(1'b1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set8(input logic [W-1:0] a, b, c, d, e, f, g, h);
    i8 = {h, g, f, e, d, c, b, a};
  endtask

  // Present i8 for one cycle, then wait until its result should be on the output.
  task automatic one_beat8(input logic ac, input logic la);
    v8 = 1'b1; acc8 = ac; last8 = la;
    tick;
    v8 = 1'b0; acc8 = 1'b0; last8 = 1'b0;
    repeat (3) tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; v8 = 1'b0; acc8 = 1'b0; last8 = 1'b0; ordy = 1'b1;
    i8 = '0; i5 = '0; v5 = 1'b0; i1 = '0; v1 = 1'b0;
    tick; tick;

    // Reset state
    check("rst_ovalid", ov_s, 0);
    check("rst_o", o_s, 0);
    check("rst_ovf", ovf_s, 0);
    check("rst_iready", rdy_s, 1);
    check("rst_iready_w", rdy_w, 1);
    check("rst_iready_n5", rdy5, 1);
    check("rst_iready_n1", rdy1, 1);
    rst = 1'b1;
    tick;

    // Single beat 1..8, latency 4
    set8(1, 2, 3, 4, 5, 6, 7, 8);
    v8 = 1'b1;
    tick;
    v8 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("t1_no_early", ov_s, 0);
      tick;
    end
    check("t1_valid", ov_s, 1);
    check("t1_o", o_s, 36);
    check("t1_ovf", ovf_s, 0);
    tick;
    check("t1_pulse_end", ov_s, 0);

    // Positive overflow: saturate vs wrap
    set8(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
         32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    one_beat8(1'b0, 1'b0);
    check("t2_sat_o", o_s, 32'h7FFFFFFF);
    check("t2_sat_ovf", ovf_s, 1);
    check("t2_wrap_o", o_w, 32'hFFFFFFF8);
    check("t2_wrap_ovf", ovf_w, 1);

    // Negative overflow
    set8(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
         32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    one_beat8(1'b0, 1'b0);
    check("t2n_sat_o", o_s, 32'h80000000);
    check("t2n_sat_ovf", ovf_s, 1);
    check("t2n_wrap_o", o_w, 32'h00000000);
    check("t2n_wrap_ovf", ovf_w, 1);

    // Exactly the positive limit: no overflow
    set8(32'h7FFFFFF8, 1, 1, 1, 1, 1, 1, 1);
    one_beat8(1'b0, 1'b0);
    check("t2e_sat_o", o_s, 32'h7FFFFFFF);
    check("t2e_sat_ovf", ovf_s, 0);
    check("t2e_wrap_ovf", ovf_w, 0);

    // Burst of three all-ones beats -> single -24
    nout = 0; at = 0; got[0] = '0; gotovf = 1'b0;
    set8('1, '1, '1, '1, '1, '1, '1, '1);
    for (int c = 1; c <= 10; c++) begin
      v8 = (c <= 3); acc8 = (c <= 3); last8 = (c == 3);
      tick;
      if (ov_s) begin nout++; at = c; got[0] = o_s; gotovf = ovf_s; end
    end
    v8 = 1'b0; acc8 = 1'b0; last8 = 1'b0;
    check("t3_count", nout, 1);
    check("t3_cycle", at, 6);
    check("t3_o", got[0], 32'hFFFFFFE8);
    check("t3_ovf", gotovf, 0);

    // Plain beat inside a burst is emitted alone and leaves the total untouched
    nout = 0;
    for (int c = 1; c <= 10; c++) begin
      v8 = (c <= 3);
      acc8 = (c == 1) || (c == 3);
      last8 = (c == 3);
      if (c == 1) set8(100, 0, 0, 0, 0, 0, 0, 0);
      else if (c == 2) set8(3, 4, 0, 0, 0, 0, 0, 0);
      else set8(0, 0, 0, 0, 0, 0, 0, 1);
      tick;
      if (ov_s && nout < 4) begin got[nout] = o_s; nout++; end
    end
    v8 = 1'b0; acc8 = 1'b0; last8 = 1'b0;
    check("t3b_count", nout, 2);
    check("t3b_plain", got[0], 7);
    check("t3b_total", got[1], 101);

    // Back-to-back beats with a three-cycle downstream stall
    sums[0] = 10; sums[1] = 20; sums[2] = 30;
    nxt = 0; nout = 0;
    for (int c = 1; c <= 16; c++) begin
      logic offer;
      offer = (nxt < 2) || ((nxt == 2) && (c >= 6));
      v8 = offer;
      if (nxt < 3) set8(sums[nxt], 0, 0, 0, 0, 0, 0, 0);
      ordy = !((c >= 6) && (c <= 8));
      #1;
      if (c >= 6 && c <= 8) begin
        check("t4_stall_iready", rdy_s, 0);
        check("t4_stall_ovalid", ov_s, 1);
        check("t4_stall_hold", o_s, 20);
      end
      if (ov_s && ordy && nout < 4) begin got[nout] = o_s; nout++; end
      if (offer && rdy_s) nxt++;
      @(posedge clk);
      #1;
    end
    v8 = 1'b0; ordy = 1'b1;
    check("t4_count", nout, 3);
    check("t4_first", got[0], 10);
    check("t4_second", got[1], 20);
    check("t4_third", got[2], 30);

    // Reset mid-burst discards the partial sum
    set8(100, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      v8 = 1'b1; acc8 = 1'b1; last8 = 1'b0;
      tick;
    end
    v8 = 1'b0; acc8 = 1'b0;
    repeat (6) tick;
    rst = 1'b0;
    tick;
    check("t5_in_rst", ov_s, 0);
    tick;
    rst = 1'b1;
    check("t5_in_rst2", ov_s, 0);
    tick;
    check("t5_after_rst", ov_s, 0);
    set8(2, 3, 0, 0, 0, 0, 0, 0);
    one_beat8(1'b1, 1'b1);
    check("t5_valid", ov_s, 1);
    check("t5_o", o_s, 5);

    // NUM=5 with padding
    i5 = {32'd7, 32'd6, 32'hFFFFFFFB, 32'd4, 32'hFFFFFFFD};
    v5 = 1'b1;
    tick;
    v5 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("t6_n5_no_early", ov5, 0);
      tick;
    end
    check("t6_n5_valid", ov5, 1);
    check("t6_n5_o", o5, 9);
    check("t6_n5_ovf", ovf5, 0);

    // NUM=1 passes the operand through after one cycle
    i1 = 32'h12345678; v1 = 1'b1;
    tick;
    i1 = 32'h80000000;
    check("t6_n1_valid", ov1, 1);
    check("t6_n1_o", o1, 32'h12345678);
    check("t6_n1_ovf", ovf1, 0);
    tick;
    v1 = 1'b0;
    check("t6_n1_neg", o1, 32'h80000000);
    check("t6_n1_neg_ovf", ovf1, 0);
    tick;
    check("t6_n1_idle", ov1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
